hazard_mc: RTL and testbench
============================

HAZARD_MC -- requirements
Module: hazard_mc

Interface
REQ-001 Parameters SHALL be: REG_AW (default 4, register-address width); PC_IDX (default 15, PC register index, never forwarded); MC_LAT (default 4, execute latency of multi-cycle ops, legal ≥2); BP_EN (default 1, branch predictor present); CNT_W (default 32, stall-counter width).
REQ-002 The block SHALL use one clock, CLK; reset is Reset, synchronous and active-high.
REQ-003 Ports, in order:
CLK  in  1  clock
Reset  in  1  synchronous active-high reset
RA1D, RA2D  in  REG_AW  decode source registers
RA1E, RA2E, WA3E  in  REG_AW  execute sources and destination
MemtoRegE, RegWriteE, PCSrcE, MCStartE  in  1  load, write, redirect, and multi-cycle op in E
WA3M, RA2M  in  REG_AW  memory-stage destination and store-data source
RegWriteM, MemWriteM, MemtoRegM, MemReadyM  in  1  memory-stage controls; MemReadyM=0 means access not complete
WA3W  in  REG_AW  write-back destination
RegWriteW, MemtoRegW  in  1  write-back controls
StallF, StallD, StallE, StallM  out  1  hold pipeline registers
FlushD, FlushE, FlushM, FlushW  out  1  bubble insertion
ForwardAE, ForwardBE  out  2  00 register file, 01 W, 10 M
ForwardM  out  1  W-to-M store-data forward
BusyMC  out  1  multi-cycle unit occupied
StallCnt  out  CNT_W  saturating count of cycles with StallF=1

Function
REQ-004 ForwardAE SHALL be 10 if RA1E==WA3M and RegWriteM; else 01 if RA1E==WA3W and RegWriteW; else 00. ForwardBE SHALL be identical with RA2E.
REQ-005 ForwardAE/ForwardBE SHALL be 00 whenever the corresponding source equals PC_IDX.
REQ-006 ForwardM SHALL be (RA2M==WA3W) & MemWriteM & MemtoRegW & RegWriteW & (RA2M!=PC_IDX).
REQ-007 MemWait SHALL be MemReadyM=0 & (MemtoRegM | MemWriteM). It SHALL assert StallF, StallD, StallE, StallM and FlushW, and it SHALL freeze the FSM and counter.
REQ-008 The FSM SHALL have states IDLE and MC_BUSY, with a down-counter of width clog2(MC_LAT).
REQ-009 In IDLE with MCStartE=1 and no MemWait, the block SHALL assert StallF/D/E and FlushM, load the counter with MC_LAT-2, and move to MC_BUSY.
REQ-010 In MC_BUSY with counter≠0 and no MemWait, the block SHALL assert StallF/D/E and FlushM, and decrement the counter.
REQ-011 In MC_BUSY with counter=0 and no MemWait, the block SHALL assert no MC stall and return to IDLE; the op spends exactly MC_LAT cycles in E.
REQ-012 BusyMC SHALL be 1 in MC_BUSY and in the start cycle of REQ-009.
REQ-013 MCStartE SHALL be ignored in MC_BUSY.
REQ-014 LDRstall SHALL be (RA1D==WA3E | RA2D==WA3E) & MemtoRegE & RegWriteE & ~PCSrcE. It SHALL assert StallF, StallD and FlushE for one cycle.
REQ-015 PCSrcE SHALL assert FlushD. It SHALL also assert FlushE when BP_EN=0.
REQ-016 PCSrcE SHALL be ignored while MemWait or BusyMC.
REQ-017 Priority SHALL be MemWait > MC stall > PCSrcE flush > LDRstall. A lower-priority condition SHALL NOT assert any flush while a higher one stalls the same stage.
REQ-018 StallCnt SHALL increment each cycle StallF=1 and saturate at all-ones.

Reset
REQ-019 On Reset=1 at a CLK edge, the FSM SHALL go to IDLE and the counter and StallCnt SHALL clear to 0.
REQ-020 While Reset=1, all Stall outputs SHALL be 0; FlushD, FlushE, FlushM and FlushW SHALL be 1; forwards SHALL be 0; BusyMC SHALL be 0.
REQ-021 Reset asserted during MC_BUSY SHALL abort the op, with IDLE on the next cycle.

Structure
REQ-022 hazard_pkg SHALL hold the FSM state enum (IDLE, MC_BUSY) and the forward-select constants FWD_RF=00, FWD_W=01, FWD_M=10.
REQ-023 The counter and FSM SHALL live in one sub-module, hazard_mc_timer (inputs: start, freeze; outputs: busy, stall). Forwarding and flush logic SHALL remain combinational in the top level.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- WA3M=3, RegWriteM=1, RA1E=3; WA3W=3, RegWriteW=1 -> ForwardAE=10. With RegWriteM=0 -> ForwardAE=01. With RA1E=WA3M=15 -> 00.
- MC_LAT=4, MCStartE=1 for one op -> StallE=1 for exactly 3 cycles, BusyMC=1 for those 3, IDLE on the 4th.
- MC_LAT=4: MemReadyM=0 with MemtoRegM=1 for 2 cycles during the 2nd MC cycle -> total StallE=5 cycles, FlushW=1 for 2 cycles.
- LDR to r2 in E with RA2D=2 -> 1-cycle StallF/StallD/FlushE. Same cycle with PCSrcE=1, BP_EN=1 -> FlushD=1, StallF=0, FlushE=0.
- Reset in the 2nd MC_BUSY cycle -> BusyMC=0 and StallCnt=0 after the edge. CNT_W=4 with 20 stall cycles -> StallCnt=15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard unit: multi-cycle FSM states
// and the operand-forward select encoding.
package hazard_pkg;

  typedef enum logic {
    IDLE,
    MC_BUSY
  } mc_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_mc_timer.sv
// Multi-cycle execute tracker: holds an op in E for MC_LAT cycles and
// freezes completely while the memory stage is waiting.
module hazard_mc_timer
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic freeze,
  output logic busy,
  output logic stall
);

  localparam int CW = $clog2(MC_LAT);
  // The start cycle is the first of the MC_LAT, and the zero-count cycle is the last.
  localparam logic [CW-1:0] LOAD = CW'(MC_LAT - 2);

  mc_state_e state;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else if (!freeze) begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= MC_BUSY;
            count <= LOAD;
          end
        end
        MC_BUSY: begin
          if (count != '0) count <= count - CW'(1);
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = !freeze && ((state == IDLE && start) || (state == MC_BUSY && count != '0));
  assign busy  = (state == MC_BUSY) || (state == IDLE && start && !freeze);

endmodule

// File: rtl/hazard_mc.sv
// Pipeline hazard unit: operand forwarding, load-use and branch handling,
// memory-wait and multi-cycle-op stalls, plus a saturating stall counter.
module hazard_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int PC_IDX = 15,
  parameter int MC_LAT = 4,
  parameter int BP_EN  = 1,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic              MemtoRegE,
  input  logic              RegWriteE,
  input  logic              PCSrcE,
  input  logic              MCStartE,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] RA2M,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemtoRegM,
  input  logic              MemReadyM,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteW,
  input  logic              MemtoRegW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardM,
  output logic              BusyMC,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam logic [REG_AW-1:0] PC = REG_AW'(PC_IDX);

  logic mem_wait, mc_stall, mc_busy, branch, ldr_raw, ldr_stall;

  assign mem_wait = !MemReadyM && (MemtoRegM || MemWriteM);

  hazard_mc_timer #(.MC_LAT(MC_LAT)) u_timer (
    .clk   (CLK),
    .reset (Reset),
    .start (MCStartE),
    .freeze(mem_wait),
    .busy  (mc_busy),
    .stall (mc_stall)
  );

  // Lower-priority hazards are masked so they never flush a stage that a higher one holds.
  assign branch    = PCSrcE && !mem_wait && !mc_busy;
  assign ldr_raw   = (RA1D == WA3E || RA2D == WA3E) && MemtoRegE && RegWriteE && !PCSrcE;
  assign ldr_stall = ldr_raw && !mem_wait && !mc_stall;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b1;
    FlushE = 1'b1;
    FlushM = 1'b1;
    FlushW = 1'b1;
    BusyMC = 1'b0;
    if (!Reset) begin
      StallF = mem_wait || mc_stall || ldr_stall;
      StallD = mem_wait || mc_stall || ldr_stall;
      StallE = mem_wait || mc_stall;
      StallM = mem_wait;
      FlushD = branch;
      FlushE = ldr_stall || (branch && BP_EN == 0);
      FlushM = mc_stall;
      FlushW = mem_wait;
      BusyMC = mc_busy;
    end
  end

  // M has priority over W; the PC register always comes from the register file.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!Reset && RA1E != PC) begin
      if (RegWriteM && RA1E == WA3M)      ForwardAE = FWD_M;
      else if (RegWriteW && RA1E == WA3W) ForwardAE = FWD_W;
    end
    if (!Reset && RA2E != PC) begin
      if (RegWriteM && RA2E == WA3M)      ForwardBE = FWD_M;
      else if (RegWriteW && RA2E == WA3W) ForwardBE = FWD_W;
    end
  end

  assign ForwardM = !Reset && (RA2M == WA3W) && MemWriteM && MemtoRegW && RegWriteW && (RA2M != PC);

  always_ff @(posedge CLK) begin
    if (Reset)                              StallCnt <= '0;
    else if (StallF && StallCnt != '1)      StallCnt <= StallCnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_mc.sv
// Directed bench for hazard_mc: a cycle-level reference model checks every
// output each cycle, and scenario checks pin the model with literal values.
module tb_hazard_mc;

  localparam int MC_LAT = 4;

  typedef struct packed {
    logic       rst;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e;
    logic       memtoreg_e, regwrite_e, pcsrc_e, mcstart_e;
    logic [3:0] wa3m, ra2m;
    logic       regwrite_m, memwrite_m, memtoreg_m, memready_m;
    logic [3:0] wa3w;
    logic       regwrite_w, memtoreg_w;
  } stim_t;

  typedef struct packed {
    logic       sf, sd, se, sm, fd, fe, fm, fw;
    logic [1:0] fa, fb;
    logic       fwm, busy;
  } exp_t;

  logic  CLK = 1'b0;
  stim_t cur;
  int    errors = 0;
  int    checks = 0;

  always #5 CLK = ~CLK;

  logic        a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fm, a_fw, a_fwm, a_busy;
  logic [1:0]  a_fa, a_fb;
  logic [31:0] a_cnt;
  logic        b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm, b_fw, b_fwm, b_busy;
  logic [1:0]  b_fa, b_fb;
  logic [3:0]  b_cnt;

  hazard_mc dut_a (
    .CLK(CLK), .Reset(cur.rst),
    .RA1D(cur.ra1d), .RA2D(cur.ra2d), .RA1E(cur.ra1e), .RA2E(cur.ra2e), .WA3E(cur.wa3e),
    .MemtoRegE(cur.memtoreg_e), .RegWriteE(cur.regwrite_e), .PCSrcE(cur.pcsrc_e), .MCStartE(cur.mcstart_e),
    .WA3M(cur.wa3m), .RA2M(cur.ra2m), .RegWriteM(cur.regwrite_m), .MemWriteM(cur.memwrite_m),
    .MemtoRegM(cur.memtoreg_m), .MemReadyM(cur.memready_m),
    .WA3W(cur.wa3w), .RegWriteW(cur.regwrite_w), .MemtoRegW(cur.memtoreg_w),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .StallM(a_sm),
    .FlushD(a_fd), .FlushE(a_fe), .FlushM(a_fm), .FlushW(a_fw),
    .ForwardAE(a_fa), .ForwardBE(a_fb), .ForwardM(a_fwm), .BusyMC(a_busy), .StallCnt(a_cnt)
  );

  hazard_mc #(.BP_EN(0), .CNT_W(4)) dut_b (
    .CLK(CLK), .Reset(cur.rst),
    .RA1D(cur.ra1d), .RA2D(cur.ra2d), .RA1E(cur.ra1e), .RA2E(cur.ra2e), .WA3E(cur.wa3e),
    .MemtoRegE(cur.memtoreg_e), .RegWriteE(cur.regwrite_e), .PCSrcE(cur.pcsrc_e), .MCStartE(cur.mcstart_e),
    .WA3M(cur.wa3m), .RA2M(cur.ra2m), .RegWriteM(cur.regwrite_m), .MemWriteM(cur.memwrite_m),
    .MemtoRegM(cur.memtoreg_m), .MemReadyM(cur.memready_m),
    .WA3W(cur.wa3w), .RegWriteW(cur.regwrite_w), .MemtoRegW(cur.memtoreg_w),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm),
    .FlushD(b_fd), .FlushE(b_fe), .FlushM(b_fm), .FlushW(b_fw),
    .ForwardAE(b_fa), .ForwardBE(b_fb), .ForwardM(b_fwm), .BusyMC(b_busy), .StallCnt(b_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic stim_t quiet();
    stim_t v;
    v = '0;
    v.memready_m = 1'b1;
    return v;
  endfunction

  // Drive one cycle's inputs just after the edge, then settle to a sample point before the next edge.
  task automatic applyStimulus(input stim_t v);
    @(posedge CLK);
    #1;
    cur = v;
    #3;
  endtask

  function automatic logic [1:0] fwdModel(input logic [3:0] src, input stim_t v);
    if (src == 4'd15)                    return 2'b00;
    if (v.regwrite_m && src == v.wa3m)   return 2'b10;
    if (v.regwrite_w && src == v.wa3w)   return 2'b01;
    return 2'b00;
  endfunction

  // 'left' is how many E-cycles the current multi-cycle op still has to spend, 0 when none.
  function automatic exp_t model(input stim_t v, input int left, input bit bp);
    exp_t e;
    logic mw, mcst, busy, br, ldr;
    e = '0;
    if (v.rst) begin
      e.fd = 1'b1; e.fe = 1'b1; e.fm = 1'b1; e.fw = 1'b1;
      return e;
    end
    mw   = !v.memready_m && (v.memtoreg_m || v.memwrite_m);
    busy = (left > 0) || (v.mcstart_e && !mw);
    mcst = !mw && ((left == 0 && v.mcstart_e) || left > 1);
    br   = v.pcsrc_e && !mw && !busy;
    ldr  = (v.ra1d == v.wa3e || v.ra2d == v.wa3e) && v.memtoreg_e && v.regwrite_e
           && !v.pcsrc_e && !mw && !mcst;
    e.sf = mw || mcst || ldr;
    e.sd = e.sf;
    e.se = mw || mcst;
    e.sm = mw;
    e.fd = br;
    e.fe = ldr || (br && !bp);
    e.fm = mcst;
    e.fw = mw;
    e.fa = fwdModel(v.ra1e, v);
    e.fb = fwdModel(v.ra2e, v);
    e.fwm = (v.ra2m == v.wa3w) && v.memwrite_m && v.memtoreg_w && v.regwrite_w && (v.ra2m != 4'd15);
    e.busy = busy;
    return e;
  endfunction

  int      mc_left = 0, nxt_left = 0;
  longint  cnt_a = 0, nxt_cnt_a = 0, cnt_b = 0, nxt_cnt_b = 0;

  // Reference comparison on every falling edge, next model state committed on the rising edge.
  always @(negedge CLK) begin
    exp_t e_a, e_b;
    logic mw;
    e_a = model(cur, mc_left, 1'b1);
    e_b = model(cur, mc_left, 1'b0);
    checkOutput("A.outputs", 64'({a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fm, a_fw, a_fa, a_fb, a_fwm, a_busy}), 64'(e_a));
    checkOutput("B.outputs", 64'({b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm, b_fw, b_fa, b_fb, b_fwm, b_busy}), 64'(e_b));
    checkOutput("A.StallCnt", 64'(a_cnt), 64'(cnt_a));
    checkOutput("B.StallCnt", 64'(b_cnt), 64'(cnt_b));
    if (cur.rst) begin
      nxt_left = 0; nxt_cnt_a = 0; nxt_cnt_b = 0;
    end else begin
      mw = !cur.memready_m && (cur.memtoreg_m || cur.memwrite_m);
      if (mw)                nxt_left = mc_left;
      else if (mc_left > 0)  nxt_left = mc_left - 1;
      else                   nxt_left = cur.mcstart_e ? MC_LAT - 1 : 0;
      nxt_cnt_a = (e_a.sf && cnt_a < 64'hFFFF_FFFF) ? cnt_a + 1 : cnt_a;
      nxt_cnt_b = (e_b.sf && cnt_b < 15) ? cnt_b + 1 : cnt_b;
    end
  end

  always @(posedge CLK) begin
    mc_left <= nxt_left;
    cnt_a   <= nxt_cnt_a;
    cnt_b   <= nxt_cnt_b;
  end

  initial begin
    stim_t v;
    int se_cnt, fw_cnt;
    cur = quiet();
    cur.rst = 1'b1;

    v = quiet(); v.rst = 1'b1;
    applyStimulus(v);
    applyStimulus(v);
    checkOutput("reset_StallF", a_sf, 0);
    checkOutput("reset_FlushD", a_fd, 1);
    checkOutput("reset_FlushW", a_fw, 1);
    checkOutput("reset_BusyMC", a_busy, 0);
    checkOutput("reset_StallCnt", a_cnt, 0);

    v = quiet(); v.wa3m = 3; v.regwrite_m = 1; v.ra1e = 3; v.ra2e = 3; v.wa3w = 3; v.regwrite_w = 1;
    applyStimulus(v);
    checkOutput("fwdA_from_M", a_fa, 2'b10);
    checkOutput("fwdB_from_M", a_fb, 2'b10);
    v.regwrite_m = 0;
    applyStimulus(v);
    checkOutput("fwdA_from_W", a_fa, 2'b01);
    v.regwrite_m = 1; v.ra1e = 15; v.wa3m = 15; v.wa3w = 15;
    applyStimulus(v);
    checkOutput("fwdA_pc_blocked", a_fa, 2'b00);

    v = quiet(); v.ra2m = 5; v.wa3w = 5; v.memwrite_m = 1; v.memtoreg_w = 1; v.regwrite_w = 1;
    applyStimulus(v);
    checkOutput("fwdM_store", a_fwm, 1);
    v.ra2m = 15; v.wa3w = 15;
    applyStimulus(v);
    checkOutput("fwdM_pc_blocked", a_fwm, 0);

    se_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      v = quiet(); v.mcstart_e = (i < MC_LAT); v.pcsrc_e = (i == 1);
      applyStimulus(v);
      if (a_se) se_cnt++;
      if (i < 3)  checkOutput("mc_busy_while_stalled", a_busy, 1);
      if (i == 1) checkOutput("mc_branch_ignored", a_fd, 0);
      if (i == 4) checkOutput("mc_idle_after_op", a_busy, 0);
    end
    checkOutput("mc_stallE_cycles", se_cnt, 3);

    se_cnt = 0; fw_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      v = quiet(); v.mcstart_e = (i < 6);
      if (i == 1 || i == 2) begin v.memtoreg_m = 1; v.memready_m = 0; end
      applyStimulus(v);
      if (a_se) se_cnt++;
      if (a_fw) fw_cnt++;
      if (i == 6) checkOutput("mw_mc_idle_after_op", a_busy, 0);
    end
    checkOutput("mw_mc_stallE_cycles", se_cnt, 5);
    checkOutput("mw_mc_flushW_cycles", fw_cnt, 2);

    v = quiet(); v.wa3e = 2; v.memtoreg_e = 1; v.regwrite_e = 1; v.ra2d = 2; v.ra1d = 7;
    applyStimulus(v);
    checkOutput("ldr_StallF", a_sf, 1);
    checkOutput("ldr_StallD", a_sd, 1);
    checkOutput("ldr_FlushE", a_fe, 1);
    checkOutput("ldr_StallE", a_se, 0);
    applyStimulus(quiet());
    checkOutput("ldr_released", a_sf, 0);
    v.pcsrc_e = 1;
    applyStimulus(v);
    checkOutput("ldr_br_FlushD", a_fd, 1);
    checkOutput("ldr_br_StallF", a_sf, 0);
    checkOutput("ldr_br_FlushE_bp", a_fe, 0);
    checkOutput("ldr_br_FlushE_nobp", b_fe, 1);

    for (int i = 0; i < 4; i++) begin
      v = quiet(); v.mcstart_e = (i < 3); v.rst = (i == 2);
      applyStimulus(v);
      if (i == 2) checkOutput("mc_reset_busy_during", a_busy, 0);
      if (i == 3) begin
        checkOutput("mc_reset_busy_after", a_busy, 0);
        checkOutput("mc_reset_cnt_after", a_cnt, 0);
      end
    end

    for (int i = 0; i < 20; i++) begin
      v = quiet(); v.memtoreg_m = 1; v.memready_m = 0;
      applyStimulus(v);
    end
    applyStimulus(quiet());
    checkOutput("cnt32_after_20", a_cnt, 20);
    checkOutput("cnt4_saturated", b_cnt, 15);

    applyStimulus(quiet());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
